// File: rtl/pkt_merge_arb_pkg.sv
// Shared definitions for the packet merge arbiter: FSM state encoding
// and default stream widths.
package pkt_merge_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  localparam int DEF_DATA_WIDTH  = 512;
  localparam int DEF_TUSER_WIDTH = 128;

endpackage

// File: rtl/pkt_merge_arb_axis_out_reg.sv
// Output register stage for the merged AXI-Stream. Captures one beat per
// load and holds it unchanged while the downstream stalls.
module axis_out_reg #(
  parameter int DW = 512,
  parameter int KW = 64,
  parameter int TW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_tdata,
  input  logic [KW-1:0] s_tkeep,
  input  logic [TW-1:0] s_tuser,
  input  logic          s_tlast,
  output logic          s_ready,
  output logic [DW-1:0] m_axis_tdata,
  output logic [KW-1:0] m_axis_tkeep,
  output logic [TW-1:0] m_axis_tuser,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready
);

  // The register can take a new beat when empty or when its current beat
  // leaves on this same edge.
  assign s_ready = !m_axis_tvalid || m_axis_tready;

  // Load on accepted beat, clear valid once drained, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (s_valid && s_ready) begin
      m_axis_tdata  <= s_tdata;
      m_axis_tkeep  <= s_tkeep;
      m_axis_tuser  <= s_tuser;
      m_axis_tlast  <= s_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/pkt_merge_arb.sv
// Two-input AXI-Stream packet merger. Grants one input for a whole packet
// and forwards it through a registered output stage.
// Build option: PKT_MERGE_ARB_STRICT_PRIO_EN gives input 1 fixed priority on
// ties; without it ties are resolved round-robin.
module pkt_merge_arb
  import pkt_merge_arb_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                              s0_axis_tvalid,
  input  logic                              s0_axis_tlast,
  output logic                              s0_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                              s1_axis_tvalid,
  input  logic                              s1_axis_tlast,
  output logic                              s1_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       pkt_cnt0,
  output logic [31:0]                       pkt_cnt1
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int TW = C_S_AXIS_TUSER_WIDTH;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [31:0]   cnt0_q;
  logic [31:0]   cnt1_q;
  logic          out_rdy;
  logic          acc0;
  logic          acc1;
  logic          sel_valid;
  logic [DW-1:0] sel_tdata;
  logic [KW-1:0] sel_tkeep;
  logic [TW-1:0] sel_tuser;
  logic          sel_tlast;

`ifndef PKT_MERGE_ARB_STRICT_PRIO_EN
  // Input that completed the most recent packet; 1 after reset so that
  // input 0 wins the first tie.
  logic          last_q;
`endif

  assign s0_axis_tready = (state_q == ST_GRANT0) && out_rdy;
  assign s1_axis_tready = (state_q == ST_GRANT1) && out_rdy;

  assign acc0 = s0_axis_tvalid && s0_axis_tready;
  assign acc1 = s1_axis_tvalid && s1_axis_tready;

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

  // Steer the granted input towards the output register.
  always_comb begin
    sel_valid = acc0 || acc1;
    sel_tdata = s0_axis_tdata;
    sel_tkeep = s0_axis_tkeep;
    sel_tuser = s0_axis_tuser;
    sel_tlast = s0_axis_tlast;
    if (state_q == ST_GRANT1) begin
      sel_tdata = s1_axis_tdata;
      sel_tkeep = s1_axis_tkeep;
      sel_tuser = s1_axis_tuser;
      sel_tlast = s1_axis_tlast;
    end
  end

  // Packet-granular arbitration: a grant ends only when its tlast is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
`ifdef PKT_MERGE_ARB_STRICT_PRIO_EN
          state_d = ST_GRANT1;
`else
          state_d = last_q ? ST_GRANT0 : ST_GRANT1;
`endif
        end else if (s0_axis_tvalid) begin
          state_d = ST_GRANT0;
        end else if (s1_axis_tvalid) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT0: if (acc0 && s0_axis_tlast) state_d = ST_IDLE;
      ST_GRANT1: if (acc1 && s1_axis_tlast) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, packet counters and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
`ifndef PKT_MERGE_ARB_STRICT_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (acc0 && s0_axis_tlast) begin
        cnt0_q <= cnt0_q + 32'd1;
`ifndef PKT_MERGE_ARB_STRICT_PRIO_EN
        last_q <= 1'b0;
`endif
      end
      if (acc1 && s1_axis_tlast) begin
        cnt1_q <= cnt1_q + 32'd1;
`ifndef PKT_MERGE_ARB_STRICT_PRIO_EN
        last_q <= 1'b1;
`endif
      end
    end
  end

  axis_out_reg #(
    .DW(DW),
    .KW(KW),
    .TW(TW)
  ) u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (sel_valid),
    .s_tdata      (sel_tdata),
    .s_tkeep      (sel_tkeep),
    .s_tuser      (sel_tuser),
    .s_tlast      (sel_tlast),
    .s_ready      (out_rdy),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

endmodule

// File: tb/tb_pkt_merge_arb.sv
// Scoreboard bench for pkt_merge_arb with narrow 64-bit data / 16-bit tuser.
module tb_pkt_merge_arb;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic [TW-1:0] s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
  logic          s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
  logic          s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
  logic          s0_axis_tready, s1_axis_tready, m_axis_tready;
  logic [31:0]   pkt_cnt0, pkt_cnt1;

  typedef struct {
    logic [63:0] d;
    logic [15:0] u;
    logic [7:0]  k;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   obs_cyc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  pkt_merge_arb #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s0_axis_tdata (s0_axis_tdata),
    .s0_axis_tkeep (s0_axis_tkeep),
    .s0_axis_tuser (s0_axis_tuser),
    .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast (s0_axis_tlast),
    .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata (s1_axis_tdata),
    .s1_axis_tkeep (s1_axis_tkeep),
    .s1_axis_tuser (s1_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast (s1_axis_tlast),
    .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_cnt0      (pkt_cnt0),
    .pkt_cnt1      (pkt_cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_data(input int p, input int id, input int b);
    return {8'(p), 8'(id), 8'(b), 8'h5A, 8'(p + 1), 8'(id), 8'(b), 8'hA5};
  endfunction

  task automatic push_pkt(input int p, input int id, input int nb);
    exp_t e;
    for (int b = 0; b < nb; b++) begin
      e.d = mk_data(p, id, b);
      e.u = {8'(id), 8'(b)};
      e.l = (b == nb - 1);
      e.k = e.l ? 8'h0F : 8'hFF;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_src(input int p, input logic v, input int id, input int b, input logic l);
    logic [63:0] d;
    logic [15:0] u;
    logic [7:0]  k;
    d = v ? mk_data(p, id, b) : 64'h0;
    u = v ? {8'(id), 8'(b)} : 16'h0;
    k = v ? (l ? 8'h0F : 8'hFF) : 8'h0;
    if (p == 0) begin
      s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tuser = u;
      s0_axis_tkeep = k;  s0_axis_tlast = v & l;
    end else begin
      s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tuser = u;
      s1_axis_tkeep = k;  s1_axis_tlast = v & l;
    end
  endtask

  // Called at a falling edge; presents each beat until the DUT takes it.
  task automatic send(input int p, input int id, input int nb);
    for (int b = 0; b < nb; b++) begin
      int  t;
      bit  done;
      t = 0;
      done = 0;
      set_src(p, 1'b1, id, b, b == nb - 1);
      while (!done) begin
        #1;
        if ((p == 0) ? s0_axis_tready : s1_axis_tready) done = 1;
        @(negedge clk);
        t++;
        if (!done && t > 200) begin
          chk("send_timeout", 64'd1, 64'd0);
          set_src(p, 1'b0, 0, 0, 1'b0);
          return;
        end
      end
    end
    set_src(p, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every consumed beat, checks hold on stall.
  initial begin
    logic        stalled_prev;
    logic [63:0] prev_d;
    exp_t        e;
    stalled_prev = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) begin
          chk("hold_vld", 64'(m_axis_tvalid), 64'd1);
          chk("hold_data", m_axis_tdata, prev_d);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          obs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("extra_beat", m_axis_tdata, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", m_axis_tdata, e.d);
            chk("out_user", 64'(m_axis_tuser), 64'(e.u));
            chk("out_keep", 64'(m_axis_tkeep), 64'(e.k));
            chk("out_last", 64'(m_axis_tlast), 64'(e.l));
          end
        end
        if (m_axis_tvalid && !m_axis_tready) begin
          chk("stall_rdy0", 64'(s0_axis_tready), 64'd0);
          chk("stall_rdy1", 64'(s1_axis_tready), 64'd0);
        end
        stalled_prev = m_axis_tvalid && !m_axis_tready;
        prev_d = m_axis_tdata;
      end
    end
  end

  initial begin
    int start;
    int base;
    int t;
    rst = 1'b1;
    m_axis_tready = 1'b1;
    set_src(0, 1'b0, 0, 0, 1'b0);
    set_src(1, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_vld", 64'(m_axis_tvalid), 64'd0);
    chk("rst_data", m_axis_tdata, 64'd0);
    chk("rst_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("rst_cnt1", 64'(pkt_cnt1), 64'd0);
    chk("rst_rdy0", 64'(s0_axis_tready), 64'd0);
    chk("rst_rdy1", 64'(s1_axis_tready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single source, 3-beat packet: beats out at +2, +3, +4.
    push_pkt(0, 1, 3);
    start = cyc;
    base = obs_cyc.size();
    send(0, 1, 3);
    drain();
    if (obs_cyc.size() >= base + 3) begin
      chk("lat_b0", 64'(obs_cyc[base] - start), 64'd2);
      chk("lat_b1", 64'(obs_cyc[base + 1] - start), 64'd3);
      chk("lat_b2", 64'(obs_cyc[base + 2] - start), 64'd4);
    end else begin
      chk("lat_beats", 64'(obs_cyc.size() - base), 64'd3);
    end
    chk("cnt0_a", 64'(pkt_cnt0), 64'd1);

    // Both valid after reset: input 0 first, whole packets.
    pulse_rst();
    push_pkt(0, 2, 2);
    push_pkt(1, 2, 2);
    fork
      send(0, 2, 2);
      send(1, 2, 2);
    join
    drain();
    chk("cnt0_b", 64'(pkt_cnt0), 64'd1);
    chk("cnt1_b", 64'(pkt_cnt1), 64'd1);

    // Continuous single-beat packets on both inputs.
`ifdef PKT_MERGE_ARB_STRICT_PRIO_EN
    for (int i = 0; i < 4; i++) push_pkt(1, 20 + i, 1);
    for (int i = 0; i < 4; i++) push_pkt(0, 10 + i, 1);
`else
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 10 + i, 1);
      push_pkt(1, 20 + i, 1);
    end
`endif
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 10 + i, 1);
      end
      begin
        for (int i = 0; i < 4; i++) send(1, 20 + i, 1);
      end
    join
    drain();
    chk("cnt0_c", 64'(pkt_cnt0), 64'd5);
    chk("cnt1_c", 64'(pkt_cnt1), 64'd5);

    // Downstream stall of 3 cycles in the middle of a 4-beat packet.
    push_pkt(0, 30, 4);
    fork
      send(0, 30, 4);
      begin
        repeat (3) @(negedge clk);
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        m_axis_tready = 1'b1;
      end
    join
    drain();
    chk("cnt0_d", 64'(pkt_cnt0), 64'd6);

    // Reset while the second beat of an s1 packet is pending.
    m_axis_tready = 1'b0;
    set_src(1, 1'b1, 40, 0, 1'b0);
    t = 0;
    #1;
    while (!s1_axis_tready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("abort_grant", 64'(s1_axis_tready), 64'd1);
    @(negedge clk);
    set_src(1, 1'b1, 40, 1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_src(1, 1'b0, 0, 0, 1'b0);
    #1;
    chk("abort_vld", 64'(m_axis_tvalid), 64'd0);
    chk("abort_data", m_axis_tdata, 64'd0);
    chk("abort_last", 64'(m_axis_tlast), 64'd0);
    chk("abort_user", 64'(m_axis_tuser), 64'd0);
    chk("abort_keep", 64'(m_axis_tkeep), 64'd0);
    chk("abort_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("abort_cnt1", 64'(pkt_cnt1), 64'd0);
    chk("abort_state", 64'(dut.state_q), 64'd0);
    chk("abort_rdy0", 64'(s0_axis_tready), 64'd0);
    chk("abort_rdy1", 64'(s1_axis_tready), 64'd0);
    @(negedge clk);
    m_axis_tready = 1'b1;
    push_pkt(0, 41, 2);
    send(0, 41, 2);
    drain();
    chk("after_abort_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("after_abort_cnt1", 64'(pkt_cnt1), 64'd0);

    // Counter wrap at 2^32.
    force dut.cnt0_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt0_q;
    chk("wrap_pre", 64'(pkt_cnt0), 64'hFFFF_FFFF);
    @(negedge clk);
    push_pkt(0, 50, 1);
    send(0, 50, 1);
    drain();
    chk("wrap_cnt0", 64'(pkt_cnt0), 64'd0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
